// File: rtl/cgra_cfg_pkg.sv
// rtl/cgra_cfg_pkg.sv - shared defaults, FSM state encoding and PE frame layout
// Contents:
//   FRAME_W_DEF    default PE configuration frame width
//   cfg_state_e    sequencer states IDLE / RUN / DONE
//   *_LSB / *_W    bit positions of the fields inside a PE frame
//   pe_frame_pack  assembles a frame from its fields (used by tooling and benches)
package cgra_cfg_pkg;

  localparam int FRAME_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cfg_state_e;

  // PE frame field layout; bits above IMM are reserved and left zero
  localparam int OP_LSB       = 0;
  localparam int OP_W         = 6;
  localparam int SRC0_LSB     = 6;
  localparam int SRC1_LSB     = 10;
  localparam int DST_LSB      = 14;
  localparam int REG_W        = 4;
  localparam int ROUTE_LSB    = 18;
  localparam int ROUTE_W      = 4;
  localparam int PRED_EN_BIT  = 22;
  localparam int PRED_INV_BIT = 23;
  localparam int IMM_LSB      = 24;
  localparam int IMM_W        = 16;

  function automatic logic [FRAME_W_DEF-1:0] pe_frame_pack(
    input logic [OP_W-1:0]    op_code,
    input logic [REG_W-1:0]   src0,
    input logic [REG_W-1:0]   src1,
    input logic [REG_W-1:0]   dst,
    input logic [ROUTE_W-1:0] route,
    input logic               pred_en,
    input logic               pred_inv,
    input logic [IMM_W-1:0]   imm
  );
    logic [FRAME_W_DEF-1:0] f;
    f = '0;
    f[OP_LSB +: OP_W]       = op_code;
    f[SRC0_LSB +: REG_W]    = src0;
    f[SRC1_LSB +: REG_W]    = src1;
    f[DST_LSB +: REG_W]     = dst;
    f[ROUTE_LSB +: ROUTE_W] = route;
    f[PRED_EN_BIT]          = pred_en;
    f[PRED_INV_BIT]         = pred_inv;
    f[IMM_LSB +: IMM_W]     = imm;
    return f;
  endfunction

endpackage

// File: rtl/cgra_ctx_mem.sv
// rtl/cgra_ctx_mem.sv - context frame storage, 1 write port, 1 asynchronous read port
// Ports:
//   clk           write clock
//   we/waddr/wdata synchronous write
//   raddr/rdata   combinational read
// The array has no reset so stored contexts survive a sequencer reset.
module cgra_ctx_mem #(
  parameter int FRAME_W   = 64,
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [CTX_AW-1:0]  waddr,
  input  logic [FRAME_W-1:0] wdata,
  input  logic [CTX_AW-1:0]  raddr,
  output logic [FRAME_W-1:0] rdata
);

  logic [FRAME_W-1:0] mem_q [CTX_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// rtl/cgra_cfg_sequencer.sv - plays stored context frames to a PE with looping, hold and abort
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data        context write (accepted only while idle)
//   start/ctx_first/ctx_last/loop_count  playback request and its range / extra passes
//   hold, abort                  stall / cancel playback
//   config_frame, config_valid   registered frame to the PE
//   busy, done, wr_err           status; done and wr_err are one-cycle pulses
//   pc, pass_cnt                 current context pointer and pass index
module cgra_cfg_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4,
  parameter int LOOP_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CTX_AW-1:0]  wr_addr,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic               start,
  input  logic [CTX_AW-1:0]  ctx_first,
  input  logic [CTX_AW-1:0]  ctx_last,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               hold,
  input  logic               abort,
  output logic [FRAME_W-1:0] config_frame,
  output logic               config_valid,
  output logic               busy,
  output logic               done,
  output logic               wr_err,
  output logic [CTX_AW-1:0]  pc,
  output logic [LOOP_W-1:0]  pass_cnt
);

  cfg_state_e         state_q, state_d;
  logic [CTX_AW-1:0]  pc_q, pc_d, first_q, first_d, last_q, last_d;
  logic [LOOP_W-1:0]  pass_q, pass_d, loop_q, loop_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               wr_err_q, wr_err_d;
  // Set when the final frame has been registered: the next RUN edge only
  // retires it (valid drops) and moves to DONE, so DONE never overlaps a frame.
  logic               fin_q, fin_d;
  logic [FRAME_W-1:0] rd_data;
  logic               mem_we;

  assign mem_we = wr_en && (state_q == ST_IDLE);

  cgra_ctx_mem #(
    .FRAME_W  (FRAME_W),
    .CTX_DEPTH(CTX_DEPTH),
    .CTX_AW   (CTX_AW)
  ) u_ctx_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(pc_q),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      pass_q   <= '0;
      first_q  <= '0;
      last_q   <= '0;
      loop_q   <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pass_q   <= pass_d;
      first_q  <= first_d;
      last_q   <= last_d;
      loop_q   <= loop_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      wr_err_q <= wr_err_d;
      fin_q    <= fin_d;
    end
  end

  // Next-state logic; abort wins over everything else
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (fin_q) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: frame emission, pointer/pass advance, range latching
  always_comb begin
    pc_d     = pc_q;
    pass_d   = pass_q;
    first_d  = first_q;
    last_d   = last_q;
    loop_d   = loop_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    fin_d    = fin_q;
    wr_err_d = wr_en && (state_q != ST_IDLE);
    if (abort) begin
      fin_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            first_d = ctx_first;
            last_d  = ctx_last;
            loop_d  = loop_count;
            pc_d    = ctx_first;
            pass_d  = '0;
            fin_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (!fin_q && !hold) begin
            frame_d = rd_data;
            valid_d = 1'b1;
            if (pc_q != last_q) begin
              pc_d = (pc_q == CTX_AW'(CTX_DEPTH - 1)) ? '0 : pc_q + CTX_AW'(1);
            end else if (pass_q < loop_q) begin
              pc_d   = first_q;
              pass_d = pass_q + LOOP_W'(1);
            end else begin
              fin_d = 1'b1;
            end
          end
        end
        ST_DONE: fin_d = 1'b0;
        default: fin_d = 1'b0;
      endcase
    end
  end

  // Outputs
  always_comb begin
    config_frame = frame_q;
    config_valid = valid_q;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    wr_err       = wr_err_q;
    pc           = pc_q;
    pass_cnt     = pass_q;
  end

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// tb/tb_cgra_cfg_sequencer.sv - self-checking bench for cgra_cfg_sequencer
module tb_cgra_cfg_sequencer;

  localparam int FW = 64;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] ctx_first;
  logic [AW-1:0] ctx_last;
  logic [LW-1:0] loop_count;
  logic          hold;
  logic          abort;
  logic [FW-1:0] config_frame;
  logic          config_valid;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [AW-1:0] pc;
  logic [LW-1:0] pass_cnt;

  logic [FW-1:0] shadow [D];
  logic [FW-1:0] exp_q[$];
  int total;
  int bad;

  cgra_cfg_sequencer #(
    .FRAME_W  (FW),
    .CTX_DEPTH(D),
    .CTX_AW   (AW),
    .LOOP_W   (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .ctx_first   (ctx_first),
    .ctx_last    (ctx_last),
    .loop_count  (loop_count),
    .hold        (hold),
    .abort       (abort),
    .config_frame(config_frame),
    .config_valid(config_valid),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err),
    .pc          (pc),
    .pass_cnt    (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_frame"}, config_frame, '0);
    chk({nm, "_valid"}, 64'(config_valid), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_done"}, 64'(done), 0);
    chk({nm, "_wr_err"}, 64'(wr_err), 0);
    chk({nm, "_pc"}, 64'(pc), 0);
    chk({nm, "_pass"}, 64'(pass_cnt), 0);
  endtask

  task automatic wr_mem(input int a, input logic [FW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  // One playback from the current negedge. hold_at/abort_at/wr_at are the
  // number of frames already seen when that action is applied (-1 = never).
  task automatic play(input int f, input int l, input int lp, input int hold_at,
                      input int hold_len, input int abort_at, input int wr_at,
                      input string nm);
    logic [FW-1:0] got[$];
    logic [FW-1:0] last_fr;
    int span, gaps, dones, werrs, cyc, holdcnt, exp_len;
    bit fin, held_prev, abort_edge, post_done, wr_done;
    span = ((l - f) % D + D) % D + 1;
    exp_q.delete();
    for (int p = 0; p <= lp; p++)
      for (int k = 0; k < span; k++)
        exp_q.push_back(shadow[(f + k) % D]);
    gaps = 0; dones = 0; werrs = 0; cyc = 0; holdcnt = 0;
    fin = 0; held_prev = 0; abort_edge = 0; post_done = 0; wr_done = 0;
    last_fr = '0;
    ctx_first  = AW'(f);
    ctx_last   = AW'(l);
    loop_count = LW'(lp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      if (held_prev) begin
        chk({nm, "_hold_valid"}, 64'(config_valid), 0);
        chk({nm, "_hold_frame"}, config_frame, last_fr);
      end
      if (wr_err) werrs++;
      if (abort_edge) begin
        chk({nm, "_abort_busy"}, 64'(busy), 0);
        chk({nm, "_abort_valid"}, 64'(config_valid), 0);
        chk({nm, "_abort_done"}, 64'(done), 0);
        fin = 1;
      end else if (post_done) begin
        chk({nm, "_after_done_busy"}, 64'(busy), 0);
        chk({nm, "_after_done_done"}, 64'(done), 0);
        fin = 1;
      end else if (done) begin
        dones++;
        chk({nm, "_done_busy"}, 64'(busy), 1);
        chk({nm, "_done_valid"}, 64'(config_valid), 0);
        post_done = 1;
      end else if (config_valid) begin
        got.push_back(config_frame);
        last_fr = config_frame;
      end else if (got.size() > 0) begin
        gaps++;
      end
      hold = 1'b0; abort = 1'b0; wr_en = 1'b0;
      held_prev = 0; abort_edge = 0;
      if (!fin && !post_done) begin
        if (hold_at >= 0 && got.size() == hold_at && holdcnt < hold_len) begin
          hold = 1'b1; holdcnt++; held_prev = 1;
        end
        if (abort_at >= 0 && got.size() == abort_at) begin
          abort = 1'b1; abort_edge = 1;
        end
        if (wr_at >= 0 && got.size() == wr_at && !wr_done) begin
          wr_en = 1'b1; wr_addr = AW'(3); wr_data = 64'hDEAD; wr_done = 1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    hold = 1'b0; abort = 1'b0; wr_en = 1'b0;
    chk({nm, "_finished"}, 64'(fin), 1);
    exp_len = (abort_at >= 0) ? abort_at : exp_q.size();
    chk({nm, "_frame_count"}, 64'(got.size()), 64'(exp_len));
    for (int i = 0; i < exp_len && i < got.size(); i++)
      chk($sformatf("%s_frame%0d", nm, i), got[i], exp_q[i]);
    if (abort_at >= 0) begin
      repeat (3) begin
        chk({nm, "_no_late_done"}, 64'(done), 0);
        @(negedge clk);
      end
    end else begin
      chk({nm, "_done_pulses"}, 64'(dones), 1);
      chk({nm, "_gaps"}, 64'(gaps), 64'((hold_at >= 0) ? hold_len : 0));
    end
    chk({nm, "_wr_err_pulses"}, 64'(werrs), 64'((wr_at >= 0) ? 1 : 0));
  endtask

  initial begin : main
    int n;
    int cyc;
    total = 0; bad = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; ctx_first = '0; ctx_last = '0; loop_count = '0;
    hold = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < D; i++) wr_mem(i, 64'h100 + 64'(i));

    play(2, 4, 1, -1, 0, -1, -1, "loop");
    play(14, 1, 0, -1, 0, -1, -1, "wrap");
    play(0, 3, 0, 2, 3, -1, -1, "hold");
    play(0, 5, 0, -1, 0, -1, 1, "wrerr");
    play(3, 3, 0, -1, 0, -1, -1, "single");
    play(0, 7, 0, -1, 0, 2, -1, "abort");
    play(1, 2, 0, -1, 0, -1, -1, "after_abort");

    // Reset in the middle of a long playback
    ctx_first = AW'(0); ctx_last = AW'(15); loop_count = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      if (config_valid) n++;
      @(negedge clk);
      cyc++;
    end
    chk("midrun_frames_seen", 64'(n), 2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(config_valid), 0);
    chk("async_rst_busy", 64'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk_idle_outputs("midrun_rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    play(5, 9, 0, -1, 0, -1, -1, "post_reset");

    for (int it = 0; it < 8; it++) begin : rnd
      int f, l, lp, tot, ha;
      repeat (2) wr_mem(int'($urandom_range(0, D - 1)), {$urandom, $urandom});
      f   = int'($urandom_range(0, D - 1));
      l   = int'($urandom_range(0, D - 1));
      lp  = int'($urandom_range(0, 2));
      tot = (lp + 1) * ((((l - f) % D) + D) % D + 1);
      ha  = (tot > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, tot - 1)) : -1;
      play(f, l, lp, ha, int'($urandom_range(1, 3)), -1, -1, $sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
